geogenius_exibe_sequencia: RTL and testbench

GEOGENIUS_EXIBE_SEQUENCIA -- requirements
Module: geogenius_exibe_sequencia

---
 rtl/geogenius_exibe_sequencia.sv | 150 +++++++++++++++
 tb/tb_geogenius_exibe_sequencia.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/geogenius_exibe_sequencia.sv
// Sequence display engine: plays memory patterns 0..rodada on the LEDs,
// each one lit for an on-time followed by a dark gap, then pulses pronto.
module geogenius_exibe_sequencia #(
    parameter int T_ON         = 500,
    parameter int T_OFF        = 250,
    parameter int T_ON_RAPIDO  = 250,
    parameter int T_OFF_RAPIDO = 125
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [3:0] rodada,
    input  logic       dificuldade,
    input  logic [7:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [7:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // Timer must reach the largest (duration - 1) of all four timings.
    localparam int MAX_NORMAL = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int MAX_RAPIDO = (T_ON_RAPIDO > T_OFF_RAPIDO) ? T_ON_RAPIDO : T_OFF_RAPIDO;
    localparam int MAX_T      = (MAX_NORMAL > MAX_RAPIDO) ? MAX_NORMAL : MAX_RAPIDO;
    localparam int TW         = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] LIM_ON      = TW'(T_ON - 1);
    localparam logic [TW-1:0] LIM_OFF     = TW'(T_OFF - 1);
    localparam logic [TW-1:0] LIM_ON_RAP  = TW'(T_ON_RAPIDO - 1);
    localparam logic [TW-1:0] LIM_OFF_RAP = TW'(T_OFF_RAPIDO - 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    end_q, end_d;
    logic [3:0]    rodada_q, rodada_d;
    logic          dif_q, dif_d;
    logic [7:0]    leds_q, leds_d;
    logic [TW-1:0] lim_on, lim_off;

    // Timing limits follow the difficulty latched at start, not the live input.
    assign lim_on  = dif_q ? LIM_ON_RAP  : LIM_ON;
    assign lim_off = dif_q ? LIM_OFF_RAP : LIM_OFF;

    // State register and datapath registers; reset clears everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
            end_q    <= '0;
            rodada_q <= '0;
            dif_q    <= 1'b0;
            leds_q   <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            end_q    <= end_d;
            rodada_q <= rodada_d;
            dif_q    <= dif_d;
            leds_q   <= leds_d;
        end
    end

    // Next-state and datapath update; abort overrides every non-idle state.
    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        end_d    = end_q;
        rodada_d = rodada_q;
        dif_d    = dif_q;
        leds_d   = leds_q;

        case (estado_q)
            OCIOSO: begin
                end_d   = '0;
                leds_d  = '0;
                timer_d = '0;
                if (iniciar && !parar) begin
                    estado_d = CARREGA;
                    rodada_d = rodada;
                    dif_d    = dificuldade;
                end
            end
            CARREGA: begin
                // Pattern shown exactly as stored, even if several bits are set.
                leds_d   = dado_memoria;
                timer_d  = '0;
                estado_d = ACESO;
            end
            ACESO: begin
                if (timer_q == lim_on) begin
                    timer_d  = '0;
                    leds_d   = '0;
                    estado_d = APAGADO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            APAGADO: begin
                leds_d = '0;
                if (timer_q == lim_off) begin
                    timer_d  = '0;
                    estado_d = (end_q == rodada_q) ? FIM : PROXIMO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PROXIMO: begin
                // Only reached when end_q < rodada_q, so this never wraps.
                end_d    = end_q + 4'd1;
                estado_d = CARREGA;
            end
            FIM: begin
                leds_d   = '0;
                end_d    = '0;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
                end_d    = '0;
                leds_d   = '0;
                timer_d  = '0;
            end
        endcase

        if (parar && (estado_q != OCIOSO)) begin
            estado_d = OCIOSO;
            end_d    = '0;
            leds_d   = '0;
            timer_d  = '0;
        end
    end

    assign endereco  = end_q;
    assign leds      = leds_q;
    assign ocupado   = (estado_q != OCIOSO);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_geogenius_exibe_sequencia.sv
// Randomized self-checking bench: a per-cycle trace of expected outputs is
// generated from the playback rules and compared against the DUT.
module tb_geogenius_exibe_sequencia;

    localparam int TON   = 4;
    localparam int TOFF  = 2;
    localparam int TONR  = 2;
    localparam int TOFFR = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [3:0] rodada;
    logic       dificuldade;
    logic [7:0] dado_memoria;
    logic [3:0] endereco;
    logic [7:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [7:0] mem [16];
    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q [$];

    geogenius_exibe_sequencia #(
        .T_ON(TON), .T_OFF(TOFF), .T_ON_RAPIDO(TONR), .T_OFF_RAPIDO(TOFFR)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
        .rodada(rodada), .dificuldade(dificuldade), .dado_memoria(dado_memoria),
        .endereco(endereco), .leds(leds), .ocupado(ocupado), .pronto(pronto),
        .db_estado(db_estado)
    );

    assign dado_memoria = mem[endereco];

    always #5 clock = ~clock;

    // Packed observation: {state, address, leds, pronto, ocupado}
    function automatic logic [17:0] rec(int st, int a, logic [7:0] l, bit pr);
        return {4'(st), 4'(a), l, pr, (st != 0)};
    endfunction

    function automatic logic [17:0] obs();
        return {db_estado, endereco, leds, pronto, ocupado};
    endfunction

    // Expected trace starting at cycle 1 after the starting edge.
    function automatic void build(int rod, bit dif, bit tail_idle);
        int ton;
        int toff;
        ton  = dif ? TONR  : TON;
        toff = dif ? TOFFR : TOFF;
        exp_q.delete();
        for (int i = 0; i <= rod; i++) begin
            exp_q.push_back(rec(1, i, 8'h00, 1'b0));
            for (int k = 0; k < ton; k++)  exp_q.push_back(rec(2, i, mem[i], 1'b0));
            for (int k = 0; k < toff; k++) exp_q.push_back(rec(3, i, 8'h00, 1'b0));
            if (i < rod) exp_q.push_back(rec(4, i, 8'h00, 1'b0));
        end
        exp_q.push_back(rec(5, rod, 8'h00, 1'b1));
        if (tail_idle) exp_q.push_back(rec(0, 0, 8'h00, 1'b0));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(int rod, bit dif);
        rodada      = 4'(rod);
        dificuldade = dif;
        iniciar     = 1'b1;
        step();
        iniciar     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 0; parar = 0; rodada = 0; dificuldade = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        #2;
        checks++;
        if (obs() !== 18'h0) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs(), 18'h0);
        end
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if (obs() !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=%h", obs(), 18'h0);
        end
    endtask

    task automatic test_single();
        mem[0] = 8'h04;
        build(0, 1'b0, 1'b1);
        start(0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (obs() !== exp_q[c]) begin
                errors++;
                $display("FAIL single cyc%0d got=%h exp=%h", c + 1, obs(), exp_q[c]);
            end
            step();
        end
    endtask

    task automatic test_three();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h80;
        build(2, 1'b0, 1'b1);
        start(2, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (obs() !== exp_q[c]) begin
                errors++;
                $display("FAIL three cyc%0d got=%h exp=%h", c + 1, obs(), exp_q[c]);
            end
            step();
        end
    endtask

    task automatic test_fast();
        mem[0] = 8'h5A;
        build(0, 1'b1, 1'b1);
        start(0, 1'b1);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (obs() !== exp_q[c]) begin
                errors++;
                $display("FAIL fast cyc%0d got=%h exp=%h", c + 1, obs(), exp_q[c]);
            end
            dificuldade = ~dificuldade;
            rodada      = 4'($urandom);
            step();
        end
        dificuldade = 1'b0;
    endtask

    task automatic test_parar();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        build(3, 1'b0, 1'b0);
        start(3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs() !== exp_q[c]) begin
                errors++;
                $display("FAIL parar_run cyc%0d got=%h exp=%h", c + 1, obs(), exp_q[c]);
            end
            iniciar = (c == 3);
            if (c == 9) parar = 1'b1;
            step();
        end
        parar = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs() !== 18'h0) begin
                errors++;
                $display("FAIL parar_idle cyc%0d got=%h exp=%h", c + 11, obs(), 18'h0);
            end
            step();
        end
    endtask

    task automatic test_idle_both();
        iniciar = 1'b1; parar = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs() !== 18'h0) begin
                errors++;
                $display("FAIL idle_both cyc%0d got=%h exp=%h", c, obs(), 18'h0);
            end
        end
        iniciar = 1'b0; parar = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(1, 255));
        start(1, 1'b0);
        step(); step();
        checks++;
        if (obs() !== rec(2, 0, mem[0], 1'b0)) begin
            errors++;
            $display("FAIL areset_pre got=%h exp=%h", obs(), rec(2, 0, mem[0], 1'b0));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({db_estado, leds, pronto, ocupado, endereco} !== 18'h0) begin
            errors++;
            $display("FAIL areset_mid got=%h exp=%h", obs(), 18'h0);
        end
        @(posedge clock);
        #3 reset = 1'b0;
        rodada = 4'd15; dificuldade = 1'b0; iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        build(15, 1'b0, 1'b1);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (obs() !== exp_q[c]) begin
                errors++;
                $display("FAIL r15 cyc%0d got=%h exp=%h", c + 1, obs(), exp_q[c]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int r;
        bit d;
        r = $urandom_range(0, 3);
        d = 1'($urandom);
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        build(r, d, 1'b1);
        rodada = 4'(r); dificuldade = d; iniciar = 1'b1;
        step();
        for (int run = 0; run < 2; run++) begin
            for (int c = 0; c < exp_q.size(); c++) begin
                checks++;
                if (obs() !== exp_q[c]) begin
                    errors++;
                    $display("FAIL b2b run%0d cyc%0d got=%h exp=%h", run, c + 1, obs(), exp_q[c]);
                end
                if (run == 1 && c == exp_q.size() - 1) iniciar = 1'b0;
                step();
            end
        end
        checks++;
        if (obs() !== 18'h0) begin
            errors++;
            $display("FAIL b2b_end got=%h exp=%h", obs(), 18'h0);
        end
    endtask

    task automatic test_random();
        int r;
        bit d;
        for (int it = 0; it < 6; it++) begin
            r = $urandom_range(0, 5);
            d = 1'($urandom);
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            build(r, d, 1'b1);
            start(r, d);
            for (int c = 0; c < exp_q.size(); c++) begin
                checks++;
                if (obs() !== exp_q[c]) begin
                    errors++;
                    $display("FAIL rand%0d cyc%0d got=%h exp=%h", it, c + 1, obs(), exp_q[c]);
                end
                iniciar     = (c < exp_q.size() - 2) ? 1'($urandom) : 1'b0;
                dificuldade = 1'($urandom);
                rodada      = 4'($urandom);
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_fast();
        test_parar();
        test_idle_both();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
